adc_delay_tap_ctrl: RTL and testbench



---
 rtl/adc_delay_tap_ctrl_pkg.sv | 15 +
 rtl/adc_delay_lane_cmp.sv | 13 +
 rtl/adc_delay_tap_ctrl.sv | 99 +++++++++
 tb/tb_adc_delay_tap_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adc_delay_tap_ctrl_pkg.sv
// adc_delay_tap_ctrl_pkg: FSM states and control-word field positions for the ADC delay tap controller
package adc_delay_tap_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTP,
    S_UP,
    S_DOWN,
    S_WAIT,
    S_DONE
  } state_t;
  localparam int TGT_LSB = 0;
  localparam int MASK_LSB = 8;
  localparam int RST_BIT = 30;
  localparam int COMMIT_BIT = 31;
endpackage

// File: rtl/adc_delay_lane_cmp.sv
// adc_delay_lane_cmp: per-lane compare of tracked tap against target, gated by the lane mask
module adc_delay_lane_cmp #(
  parameter int TAP_W = 5
) (
  input  logic [TAP_W-1:0] cur,
  input  logic [TAP_W-1:0] tgt,
  input  logic             en,
  output logic             up,
  output logic             down
);
  assign up = en && (cur < tgt);
  assign down = en && (cur > tgt);
endmodule

// File: rtl/adc_delay_tap_ctrl.sv
// adc_delay_tap_ctrl: steps per-lane IDELAY taps toward a software target, one tap per settle interval
module adc_delay_tap_ctrl
  import adc_delay_tap_ctrl_pkg::*;
#(
  parameter int N_LANES = 8,
  parameter int TAP_W = 5,
  parameter int SETTLE = 4
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic [31:0]              reg_word,
  output logic [N_LANES-1:0]       dly_ce,
  output logic                     dly_inc,
  output logic                     dly_rst,
  output logic                     busy,
  output logic [N_LANES*TAP_W-1:0] cur_tap,
  output logic [15:0]              apply_cnt
);
  localparam int CW = $clog2(SETTLE + 1);
  state_t state, ret;
  logic [31:0] r_word;
  logic acc_commit;
  logic [TAP_W-1:0] tgt;
  logic [N_LANES-1:0] mask, up, down;
  logic [TAP_W-1:0] tap [N_LANES];
  logic [CW-1:0] cnt;
  logic unused;
  assign unused = ^r_word;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    adc_delay_lane_cmp #(.TAP_W(TAP_W)) u_cmp (
      .cur (tap[i]),
      .tgt (tgt),
      .en  (mask[i]),
      .up  (up[i]),
      .down(down[i])
    );
    assign cur_tap[i*TAP_W +: TAP_W] = tap[i];
  end
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state <= S_IDLE;
      ret <= S_IDLE;
      r_word <= '0;
      acc_commit <= 1'b0;
      tgt <= '0;
      mask <= '0;
      cnt <= '0;
      dly_ce <= '0;
      dly_inc <= 1'b0;
      dly_rst <= 1'b0;
      busy <= 1'b0;
      apply_cnt <= '0;
      for (int i = 0; i < N_LANES; i++) tap[i] <= '0;
    end else begin
      r_word <= reg_word;
      dly_ce <= '0;
      dly_rst <= 1'b0;
      case (state)
        S_IDLE: if (r_word[COMMIT_BIT] != acc_commit) begin
          acc_commit <= r_word[COMMIT_BIT];
          tgt <= r_word[TGT_LSB +: TAP_W];
          mask <= r_word[MASK_LSB +: N_LANES];
          busy <= 1'b1;
          state <= r_word[RST_BIT] ? S_RSTP : S_UP;
        end
        S_RSTP: begin
          dly_rst <= 1'b1;
          for (int i = 0; i < N_LANES; i++) tap[i] <= '0;
          ret <= S_DONE;
          cnt <= CW'(SETTLE - 1);
          state <= S_WAIT;
        end
        S_UP: if (|up) begin
          dly_ce <= up;
          dly_inc <= 1'b1;
          for (int i = 0; i < N_LANES; i++) if (up[i]) tap[i] <= tap[i] + 1'b1;
          ret <= S_UP;
          cnt <= CW'(SETTLE - 1);
          state <= S_WAIT;
        end else state <= S_DOWN;
        S_DOWN: if (|down) begin
          dly_ce <= down;
          dly_inc <= 1'b0;
          for (int i = 0; i < N_LANES; i++) if (down[i]) tap[i] <= tap[i] - 1'b1;
          ret <= S_DOWN;
          cnt <= CW'(SETTLE - 1);
          state <= S_WAIT;
        end else state <= S_DONE;
        S_WAIT: if (cnt == '0) state <= ret; else cnt <= cnt - 1'b1;
        S_DONE: begin
          apply_cnt <= apply_cnt + 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_delay_tap_ctrl.sv
// tb_adc_delay_tap_ctrl: directed vectors with hand-computed expectations for the tap controller
module tb_adc_delay_tap_ctrl;
  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  logic [31:0] reg_word = '0;
  logic [7:0] dly_ce;
  logic dly_inc, dly_rst, busy;
  logic [39:0] cur_tap;
  logic [15:0] apply_cnt;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, np = 0, busy_cyc = 0, rst_cyc = 0, c0 = 0;
  logic [7:0] ce_log [16];
  logic inc_log [16];
  int t_log [16];

  adc_delay_tap_ctrl #(.N_LANES(8), .TAP_W(5), .SETTLE(4)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .reg_word (reg_word),
    .dly_ce   (dly_ce),
    .dly_inc  (dly_inc),
    .dly_rst  (dly_rst),
    .busy     (busy),
    .cur_tap  (cur_tap),
    .apply_cnt(apply_cnt)
  );

  always #5 user_clk = ~user_clk;

  always @(negedge user_clk) if (!user_rst) begin
    if (busy) busy_cyc++;
    if (dly_rst) rst_cyc++;
    if (dly_ce != 0) begin
      if (np < 16) begin
        ce_log[np] = dly_ce;
        inc_log[np] = dly_inc;
        t_log[np] = cyc;
      end
      np++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic clr();
    np = 0;
    busy_cyc = 0;
    rst_cyc = 0;
  endtask

  task automatic issue(input logic [31:0] w);
    clr();
    c0 = cyc;
    reg_word = w;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!busy && n < 10) begin tick(1); n++; end
    chk("busy_rise", busy, 1);
    n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    chk("busy_fall", busy, 0);
    tick(1);
  endtask

  initial begin
    tick(3);
    chk("rst_ce", dly_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_taps", cur_tap, 0);
    chk("rst_cnt", apply_cnt, 0);
    user_rst = 1'b0;
    tick(2);
    // lane 0 up to 3
    issue(32'h8000_0103);
    wait_done(100);
    chk("t1_np", np, 3);
    chk("t1_lat", t_log[0] - c0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_ce", ce_log[i], 8'h01);
      chk("t1_inc", inc_log[i], 1);
    end
    chk("t1_gap1", t_log[1] - t_log[0], 5);
    chk("t1_gap2", t_log[2] - t_log[1], 5);
    chk("t1_busy", busy_cyc, 18);
    chk("t1_tap", cur_tap, 40'h3);
    chk("t1_cnt", apply_cnt, 1);
    chk("t1_inc_hold", dly_inc, 1);
    // lanes 0,1 to 1: lane1 up once, lane0 down twice
    issue(32'h0000_0301);
    wait_done(100);
    chk("t2_np", np, 3);
    chk("t2_ce0", ce_log[0], 8'h02);
    chk("t2_inc0", inc_log[0], 1);
    chk("t2_ce1", ce_log[1], 8'h01);
    chk("t2_inc1", inc_log[1], 0);
    chk("t2_ce2", ce_log[2], 8'h01);
    chk("t2_inc2", inc_log[2], 0);
    chk("t2_busy", busy_cyc, 18);
    chk("t2_tap", cur_tap, 40'h21);
    chk("t2_cnt", apply_cnt, 2);
    // tap reset command
    issue(32'hC000_0000);
    wait_done(100);
    chk("t3_rst", rst_cyc, 1);
    chk("t3_np", np, 0);
    chk("t3_busy", busy_cyc, 6);
    chk("t3_tap", cur_tap, 0);
    chk("t3_cnt", apply_cnt, 3);
    // odd toggles while busy: one follow-up command with the final word
    issue(32'h0000_0102);
    tick(4);
    reg_word = 32'h8000_0102;
    tick(1);
    reg_word = 32'h0000_0102;
    tick(1);
    reg_word = 32'h8000_0105;
    tick(120);
    chk("t4_np", np, 5);
    chk("t4_tap", cur_tap, 40'h5);
    chk("t4_cnt", apply_cnt, 5);
    chk("t4_busy", busy, 0);
    // even toggles while busy cancel out
    issue(32'h0000_0103);
    tick(4);
    reg_word = 32'h8000_0107;
    tick(1);
    reg_word = 32'h0000_010A;
    tick(120);
    chk("t5_np", np, 2);
    chk("t5_tap", cur_tap, 40'h3);
    chk("t5_cnt", apply_cnt, 6);
    // reset mid-UP after 2 of 5 steps, then re-execution from zero
    issue(32'h8000_0108);
    for (int n = 0; n < 100 && np < 2; n++) tick(1);
    chk("t6_np2", np, 2);
    tick(1);
    chk("t6_busy_pre", busy, 1);
    user_rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tap", cur_tap, 0);
    chk("t6_rst_cnt", apply_cnt, 0);
    chk("t6_rst_ce", dly_ce, 0);
    chk("t6_rst_inc", dly_inc, 0);
    tick(2);
    user_rst = 1'b0;
    clr();
    wait_done(200);
    chk("t6_np", np, 8);
    chk("t6_busy", busy_cyc, 43);
    chk("t6_tap", cur_tap, 40'h8);
    chk("t6_cnt", apply_cnt, 1);
    // empty mask
    issue(32'h0000_0005);
    wait_done(100);
    chk("t7_np", np, 0);
    chk("t7_busy", busy_cyc, 3);
    chk("t7_tap", cur_tap, 40'h8);
    chk("t7_cnt", apply_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
